audio_clock_monitor: RTL and testbench
======================================

AUDIO_CLOCK_MONITOR -- requirements
Module: audio_clock_monitor

Interface
REQ-001 The block SHALL have parameter NOMINAL, default 2268, meaning the expected audio_clk period in clk cycles (100 MHz / 44.1 kHz).
REQ-002 The block SHALL have parameter TOL, default 4, meaning the allowed +/- deviation from NOMINAL in clk cycles.
REQ-003 The block SHALL have parameter LOCK_COUNT, default 4, meaning the consecutive in-tolerance periods required to declare lock.
REQ-004 The block SHALL have parameter TIMEOUT, default 4095, meaning the clk cycles without an edge before loss is declared.
REQ-005 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port audio_clk, input, 1 bit: incoming sample strobe, treated as asynchronous to clk.
REQ-008 Port period, output, 12 bits: last measured period in clk cycles.
REQ-009 Port period_valid, output, 1 bit: one-cycle pulse when period updates.
REQ-010 Port locked, output, 1 bit: high while the strobe is in tolerance and stable.
REQ-011 Port timeout, output, 1 bit: one-cycle pulse when TIMEOUT elapses without an edge.
REQ-012 Port err, output, 1 bit: one-cycle pulse on an out-of-tolerance period while locked.

Function
REQ-013 audio_clk SHALL pass through a 2-flop synchronizer plus one history flop; an edge event is the synchronized value high with the history flop low.
REQ-014 A level held high for N cycles SHALL produce exactly one edge event.
REQ-015 Edge-event-driven outputs SHALL be registered, giving period_valid exactly 3 clk cycles after the first clk edge that samples audio_clk high.
REQ-016 Counter cnt (12 bits) SHALL load 1 on each edge event, increment otherwise, and saturate at 4095.
REQ-017 The measured period SHALL be cnt's value at the edge event, i.e. clk cycles between successive edge events.
REQ-018 The FSM SHALL have states SEARCH, MEASURE and LOCKED.
REQ-019 SEARCH: no reference edge; the first edge event SHALL only restart cnt, move to MEASURE, and produce no period_valid.
REQ-020 MEASURE/LOCKED: every edge event SHALL update period and pulse period_valid.
REQ-021 A period is in tolerance iff NOMINAL-TOL <= period <= NOMINAL+TOL, inclusive.
REQ-022 Consecutive-good counter good_cnt SHALL count in-tolerance periods and clear to 0 on any out-of-tolerance period.
REQ-023 MEASURE SHALL go to LOCKED on the edge event that brings good_cnt to LOCK_COUNT; locked goes high in that same output cycle.
REQ-024 LOCKED with an out-of-tolerance period: err SHALL pulse, locked SHALL fall, the FSM SHALL go to MEASURE, and good_cnt SHALL be 0.
REQ-025 In any non-SEARCH state, cnt reaching TIMEOUT without an edge event SHALL pulse timeout once, drop locked, clear good_cnt, and go to SEARCH; period holds its last value.
REQ-026 In SEARCH, timeout SHALL NOT pulse.
REQ-027 If the edge event and the TIMEOUT condition coincide, the edge event SHALL win and no timeout is reported.
REQ-028 period SHALL NOT change except on period_valid.

Reset
REQ-029 While rst_n is low: synchronizer and history flops at 0, cnt=0, good_cnt=0, FSM=SEARCH, period=0, and period_valid, locked, timeout and err all 0.
REQ-030 Assertion of rst_n SHALL take effect immediately, regardless of clk, including mid-lock.
REQ-031 After deassertion, the first edge event SHALL be treated as the SEARCH reference.

Verification
REQ-032 A 1-cycle strobe every 2268 clk SHALL give no period_valid on edge 1, period=2268 on edges 2-5, and locked rising with edge 5's period_valid with err=0.
REQ-033 Tolerance boundaries when locked: periods 2264 and 2272 SHALL keep lock; a period of 2273 SHALL pulse err, drop locked, and relock after 4 further 2268 periods.
REQ-034 Stopping the strobe when locked SHALL pulse timeout exactly once, 4095 cycles after the last edge's cnt reload, with locked=0; the next edge SHALL produce no period_valid.
REQ-035 A strobe held high 10 cycles, period 2268, SHALL count one edge per period, giving period=2268.
REQ-036 rst_n pulsed low mid-lock, between clk edges, SHALL make all outputs 0 immediately, after which the lock sequence repeats exactly as in REQ-032.

Source files
------------

// File: rtl/audio_clock_monitor.sv
// audio_clock_monitor: measures the audio sample-strobe period in clk cycles.
// It declares lock after a run of in-tolerance periods, and reports
// out-of-tolerance periods while locked and loss of the strobe.
module audio_clock_monitor #(
    parameter int NOMINAL    = 2268,
    parameter int TOL        = 4,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        audio_clk,
    output logic [11:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        timeout,
    output logic        err
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam int              GW      = $clog2(LOCK_COUNT + 1);
    localparam logic [11:0]     PER_LO  = 12'(NOMINAL - TOL);
    localparam logic [11:0]     PER_HI  = 12'(NOMINAL + TOL);
    localparam logic [11:0]     TO_CNT  = 12'(TIMEOUT);
    localparam logic [11:0]     CNT_MAX = 12'hFFF;
    localparam logic [GW-1:0]   LOCK_N  = GW'(LOCK_COUNT);

    logic          r_sync1, r_sync2, r_hist, r_edge;
    logic          w_edge;
    logic [11:0]   r_cnt;
    logic [GW-1:0] r_good, w_good_next, w_good_inc;
    state_t        r_state, w_state_next;
    logic [11:0]   w_period_next;
    logic          w_pv_next, w_locked_next, w_timeout_next, w_err_next;
    logic          w_in_tol, w_expired;

    // A rising edge is the synchronized level high while the history flop is
    // still low, so a long high level yields exactly one event.
    assign w_edge = r_sync2 & ~r_hist;

    // Two-flop synchronizer, history flop, and one extra stage that registers
    // the edge event so every downstream decision sees a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= audio_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_edge  <= w_edge;
        end
    end

    // Cycle counter: restarts at 1 on each edge so its value at the next edge
    // is the period; saturates so a dead strobe cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 12'd0;
        end else if (r_edge) begin
            r_cnt <= 12'd1;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 12'd1;
        end
    end

    assign w_in_tol   = (r_cnt >= PER_LO) && (r_cnt <= PER_HI);
    assign w_expired  = (r_cnt == TO_CNT);
    assign w_good_inc = r_good + GW'(1);

    // State, good-period run length and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SEARCH;
            r_good       <= '0;
            period       <= 12'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            err          <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_good       <= w_good_next;
            period       <= w_period_next;
            period_valid <= w_pv_next;
            locked       <= w_locked_next;
            timeout      <= w_timeout_next;
            err          <= w_err_next;
        end
    end

    // Next-state and next-output decode; an edge always takes priority over
    // the loss-of-strobe check.
    always_comb begin
        w_state_next   = r_state;
        w_good_next    = r_good;
        w_period_next  = period;
        w_pv_next      = 1'b0;
        w_locked_next  = locked;
        w_timeout_next = 1'b0;
        w_err_next     = 1'b0;
        case (r_state)
            SEARCH: begin
                if (r_edge) begin
                    w_state_next  = MEASURE;
                    w_good_next   = '0;
                    w_locked_next = 1'b0;
                end
            end
            MEASURE: begin
                if (r_edge) begin
                    w_pv_next     = 1'b1;
                    w_period_next = r_cnt;
                    if (!w_in_tol) begin
                        w_good_next = '0;
                    end else if (w_good_inc >= LOCK_N) begin
                        w_good_next   = LOCK_N;
                        w_state_next  = LOCKED;
                        w_locked_next = 1'b1;
                    end else begin
                        w_good_next = w_good_inc;
                    end
                end else if (w_expired) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = SEARCH;
                    w_good_next    = '0;
                    w_locked_next  = 1'b0;
                end
            end
            LOCKED: begin
                if (r_edge) begin
                    w_pv_next     = 1'b1;
                    w_period_next = r_cnt;
                    if (!w_in_tol) begin
                        w_err_next    = 1'b1;
                        w_locked_next = 1'b0;
                        w_state_next  = MEASURE;
                        w_good_next   = '0;
                    end
                end else if (w_expired) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = SEARCH;
                    w_good_next    = '0;
                    w_locked_next  = 1'b0;
                end
            end
            default: begin
                w_state_next  = SEARCH;
                w_good_next   = '0;
                w_locked_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_audio_clock_monitor.sv
// Scoreboard bench for audio_clock_monitor: stimulus pushes the expected
// output event for each strobe edge; a negedge monitor pops and compares.
module tb_audio_clock_monitor;

    typedef struct {
        bit          pv;
        bit          to;
        bit          err;
        logic [11:0] period;
        bit          locked;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        audio_clk;
    logic [11:0] period;
    logic        period_valid, locked, timeout, err;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_pv  = 0;
    int          n_txn    = 0;
    logic [11:0] prev_period = 12'd0;

    audio_clock_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_clk    (audio_clk),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_assert++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the queue; period
    // may only move together with period_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (!period_valid) chk("period_hold", int'(period), int'(prev_period));
            if (period_valid || timeout || err) begin
                n_txn++;
                $display("txn %0d @%0d: pv=%0b to=%0b err=%0b period=%0d locked=%0b",
                         n_txn, cyc, period_valid, timeout, err, period, locked);
                if (q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("period_valid", int'(period_valid), int'(e.pv));
                    chk("timeout",      int'(timeout),      int'(e.to));
                    chk("err",          int'(err),          int'(e.err));
                    chk("period",       int'(period),       int'(e.period));
                    chk("locked",       int'(locked),       int'(e.locked));
                    if (e.gap != 0) chk("timeout_gap", cyc - last_pv, e.gap);
                end
                if (period_valid) last_pv = cyc;
            end
        end
        prev_period = period;
    end

    // One strobe: an edge now, high for 'high' cycles, next edge 'len' later.
    task automatic strobe(input int len, input int high);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1 audio_clk = (i < high);
        end
    endtask

    task automatic row(input int len, input int high, input bit push,
                       input bit e_err, input int per, input bit lk);
        if (push) q.push_back('{pv: 1'b1, to: 1'b0, err: e_err,
                                period: 12'(per), locked: lk, gap: 0});
        strobe(len, high);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"},       int'(period),       0);
        chk({tag, "_period_valid"}, int'(period_valid), 0);
        chk({tag, "_locked"},       int'(locked),       0);
        chk({tag, "_timeout"},      int'(timeout),      0);
        chk({tag, "_err"},          int'(err),          0);
    endtask

    task automatic lock_sequence(input int last_len);
        row(2268, 1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) row(2268, 1, 1'b1, 1'b0, 2268, 1'b0);
        row(last_len, 1, 1'b1, 1'b0, 2268, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        audio_clk = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle in SEARCH well past the timeout count: nothing may be reported.
        repeat (5000) @(posedge clk);

        // Lock on nominal, then walk the tolerance edges.
        row(2268, 1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) row(2268, 1, 1'b1, 1'b0, 2268, 1'b0);
        row(2264, 1, 1'b1, 1'b0, 2268, 1'b1);
        row(2272, 1, 1'b1, 1'b0, 2264, 1'b1);
        row(2273, 1, 1'b1, 1'b0, 2272, 1'b1);
        row(2268, 10, 1'b1, 1'b1, 2273, 1'b0);
        for (int k = 0; k < 3; k++) row(2268, 10, 1'b1, 1'b0, 2268, 1'b0);

        // Relocking edge, then the strobe stops: one timeout 4095 later.
        q.push_back('{pv: 1'b1, to: 1'b0, err: 1'b0, period: 12'd2268, locked: 1'b1, gap: 0});
        q.push_back('{pv: 1'b0, to: 1'b1, err: 1'b0, period: 12'd2268, locked: 1'b0, gap: 4095});
        strobe(4095 + 200, 10);

        // Back from SEARCH: first edge is only a reference again.
        lock_sequence(100);

        // Asynchronous reset mid-lock, between clock edges.
        chk("locked_before_reset", int'(locked), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midlock_reset");
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // Same lock sequence, then a 4095 period: edge beats timeout.
        lock_sequence(4095);
        q.push_back('{pv: 1'b1, to: 1'b0, err: 1'b1, period: 12'd4095, locked: 1'b0, gap: 0});
        q.push_back('{pv: 1'b0, to: 1'b1, err: 1'b0, period: 12'd4095, locked: 1'b0, gap: 4095});
        strobe(4095 + 200, 1);

        repeat (20) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
